sprite_line_engine: RTL and testbench

- Parametrised successor to the single-pass sprite line buffer: a ping-pong line renderer.
- While the display side reads line N from one bank, an FSM scans the object table and rasterises line N+1 into the other bank, one pixel per cycle, from an external sprite ROM.
- Object writes go to shadow registers and are committed at frame start, so updates never tear.
- Sits between the Avalon register slave and the VGA colour mux.

---
 rtl/sprite_pkg.sv | 26 ++
 rtl/sprite_line_bank.sv | 38 +++
 rtl/sprite_line_engine.sv | 215 +++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and writedata field positions for the sprite line engine.
// SPRITE_FLIP_EN (when defined) enables per-object horizontal flip.
package sprite_pkg;

    localparam int LINE_XW   = 10;
    localparam int OBJ_XY_W  = 12;
    localparam int OBJ_SPR_W = 6;

    // writedata = {x[31:20], y[19:8], sprite[7:2], active[1], flip[0]}
    localparam int WD_X_LO   = 20;
    localparam int WD_Y_LO   = 8;
    localparam int WD_SPR_LO = 2;
    localparam int WD_ACTIVE = 1;
    localparam int WD_FLIP   = 0;

    typedef enum logic [1:0] {CLEAR, IDLE, SCAN, DRAW} state_t;

    typedef struct packed {
        logic [OBJ_XY_W-1:0]  x;
        logic [OBJ_XY_W-1:0]  y;
        logic [OBJ_SPR_W-1:0] sprite;
        logic                 active;
        logic                 flip;
    } obj_t;

endpackage

// File: rtl/sprite_line_bank.sv
// One line of {pixel, valid} entries: a write port plus a 1-cycle
// registered read port that clears the entry it returns.
module sprite_line_bank
    import sprite_pkg::*;
#(
    parameter int LINE_W = 640,
    parameter int PIX_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LINE_XW-1:0] wr_x,
    input  logic [PIX_W:0]     wr_data,
    input  logic               rd_en,
    input  logic [LINE_XW-1:0] rd_x,
    output logic [PIX_W:0]     rd_data
);

    logic [PIX_W:0] mem [LINE_W];
    logic           rd_hit;

    assign rd_hit = rd_en && (rd_x < LINE_XW'(LINE_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_x] : '0;
        end
    end

    // Contents are invalidated by the engine's CLEAR sweep, not by reset.
    always_ff @(posedge clk) begin
        if (rd_hit) mem[rd_x] <= '0;
        if (wr_en)  mem[wr_x] <= wr_data;
    end

endmodule

// File: rtl/sprite_line_engine.sv
// Ping-pong sprite line renderer: scans the object table and rasterises the
// next line into one bank while the display reads the other. Macro: SPRITE_FLIP_EN.
module sprite_line_engine
    import sprite_pkg::*;
#(
    parameter int MAX_OBJECTS = 20,
    parameter int LINE_W      = 640,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int SPR_IDX_W   = 6,
    parameter int PIX_W       = 8,
    parameter int TRANSPARENT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 chipselect,
    input  logic                 write,
    input  logic [4:0]           address,
    input  logic [31:0]          writedata,
    input  logic                 frame_start,
    input  logic                 line_start,
    input  logic [LINE_XW-1:0]   next_line,
    input  logic                 rd_en,
    input  logic [LINE_XW-1:0]   rd_x,
    output logic [PIX_W-1:0]     pix_data,
    output logic                 pix_valid,
    output logic [SPR_IDX_W+$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0] rom_addr,
    input  logic [PIX_W-1:0]     rom_data,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CW  = $clog2(SPRITE_W);
    localparam int CW1 = CW + 1;
    localparam int RW  = $clog2(SPRITE_H);
    localparam int OW  = $clog2(MAX_OBJECTS);

    obj_t shadow [MAX_OBJECTS];
    obj_t live   [MAX_OBJECTS];
    obj_t wr_obj;
    logic reg_wr, obj_wr;

    state_t             state;
    logic [LINE_XW-1:0] clear_x, line_q;
    logic [OW-1:0]      obj_idx;
    logic [CW:0]        col;
    logic [11:0]        cur_x;
    logic [SPR_IDX_W-1:0] cur_spr;
    logic [RW-1:0]      cur_row;
    logic               p_valid;
    logic [12:0]        p_bx;
    logic               bank_sel, rd_sel;

    logic [12:0]   scan_line, scan_y;
    logic [RW-1:0] scan_row;
    logic          scan_hit, last_obj;
    logic [CW-1:0] issue_col, addr_col;
`ifdef SPRITE_FLIP_EN
    logic          cur_flip, issue_flip;
`endif

    // ---------------- register slave: shadow table and commit ----------------
    always_comb begin
        wr_obj.x      = writedata[WD_X_LO +: OBJ_XY_W];
        wr_obj.y      = writedata[WD_Y_LO +: OBJ_XY_W];
        wr_obj.sprite = writedata[WD_SPR_LO +: OBJ_SPR_W];
        wr_obj.active = writedata[WD_ACTIVE];
`ifdef SPRITE_FLIP_EN
        wr_obj.flip   = writedata[WD_FLIP];
`else
        wr_obj.flip   = 1'b0;
`endif
    end

    assign reg_wr = chipselect && write;
    assign obj_wr = reg_wr && (address != 5'd0) && (int'(address) <= MAX_OBJECTS);

    // A commit copies the pre-write shadow, so a coincident write only reaches shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_OBJECTS; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            if (frame_start) live <= shadow;
            if (obj_wr) shadow[address - 5'd1] <= wr_obj;
        end
    end

    // ---------------- scan compare and ROM column selection ----------------
    always_comb begin
        scan_line = {3'b000, line_q};
        scan_y    = {1'b0, live[obj_idx].y};
        scan_row  = line_q[RW-1:0] - live[obj_idx].y[RW-1:0];
        scan_hit  = live[obj_idx].active && (scan_line >= scan_y) &&
                    (scan_line < scan_y + 13'(SPRITE_H));
        issue_col = (state == SCAN) ? '0 : col[CW-1:0] + 1'b1;
`ifdef SPRITE_FLIP_EN
        issue_flip = (state == SCAN) ? live[obj_idx].flip : cur_flip;
        addr_col   = issue_col ^ {CW{issue_flip}};
`else
        addr_col   = issue_col;
`endif
    end

    assign last_obj = (obj_idx == OW'(MAX_OBJECTS - 1));
    assign busy     = (state != IDLE);

    // ---------------- build FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clear_x  <= '0;
            line_q   <= '0;
            obj_idx  <= '0;
            col      <= '0;
            cur_x    <= '0;
            cur_spr  <= '0;
            cur_row  <= '0;
            rom_addr <= '0;
            p_valid  <= 1'b0;
            p_bx     <= '0;
            bank_sel <= 1'b0;
            overrun  <= 1'b0;
`ifdef SPRITE_FLIP_EN
            cur_flip <= 1'b0;
`endif
        end else begin
            p_valid <= 1'b0;
            if (reg_wr && address == 5'd0 && writedata[WD_FLIP]) overrun <= 1'b0;
            if (line_start) begin
                // A pending pixel of an aborted build is dropped by the p_valid default.
                if (state != IDLE) overrun <= 1'b1;
                bank_sel <= ~bank_sel;
                line_q   <= next_line;
                obj_idx  <= '0;
                state    <= SCAN;
            end else begin
                case (state)
                    CLEAR: begin
                        clear_x <= clear_x + 1'b1;
                        if (clear_x == LINE_XW'(LINE_W - 1)) state <= IDLE;
                    end
                    IDLE: ;
                    SCAN: begin
                        if (scan_hit) begin
                            cur_x    <= live[obj_idx].x;
                            cur_spr  <= live[obj_idx].sprite;
                            cur_row  <= scan_row;
`ifdef SPRITE_FLIP_EN
                            cur_flip <= live[obj_idx].flip;
`endif
                            rom_addr <= {live[obj_idx].sprite, scan_row, addr_col};
                            col      <= '0;
                            state    <= DRAW;
                        end else if (last_obj) begin
                            state <= IDLE;
                        end else begin
                            obj_idx <= obj_idx + 1'b1;
                        end
                    end
                    DRAW: begin
                        if (!col[CW]) begin
                            p_valid <= 1'b1;
                            p_bx    <= {1'b0, cur_x} + 13'(col);
                            if (col != CW1'(SPRITE_W - 1))
                                rom_addr <= {cur_spr, cur_row, addr_col};
                            col <= col + 1'b1;
                        end else if (last_obj) begin
                            state <= IDLE;
                        end else begin
                            obj_idx <= obj_idx + 1'b1;
                            state   <= SCAN;
                        end
                    end
                    default: state <= CLEAR;
                endcase
            end
        end
    end

    // ---------------- banks: build into bank_sel, display the other ----------------
    logic               clearing, pix_wr;
    logic               wr_en0, wr_en1, rd_en0, rd_en1;
    logic [LINE_XW-1:0] wr_x;
    logic [PIX_W:0]     wr_data, rd_data0, rd_data1;

    assign clearing = (state == CLEAR);
    assign pix_wr   = p_valid && (rom_data != PIX_W'(TRANSPARENT)) && (p_bx < 13'(LINE_W));
    assign wr_x     = clearing ? clear_x : p_bx[LINE_XW-1:0];
    assign wr_data  = clearing ? '0 : {rom_data, 1'b1};
    assign wr_en0   = clearing || (pix_wr && !bank_sel);
    assign wr_en1   = clearing || (pix_wr && bank_sel);
    assign rd_en0   = rd_en && bank_sel;
    assign rd_en1   = rd_en && !bank_sel;

    always_ff @(posedge clk) begin
        if (reset)      rd_sel <= 1'b0;
        else if (rd_en) rd_sel <= ~bank_sel;
    end

    assign {pix_data, pix_valid} = rd_sel ? rd_data1 : rd_data0;

    sprite_line_bank #(.LINE_W(LINE_W), .PIX_W(PIX_W)) u_bank0 (
        .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_x(wr_x), .wr_data(wr_data),
        .rd_en(rd_en0), .rd_x(rd_x), .rd_data(rd_data0)
    );

    sprite_line_bank #(.LINE_W(LINE_W), .PIX_W(PIX_W)) u_bank1 (
        .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_x(wr_x), .wr_data(wr_data),
        .rd_en(rd_en1), .rd_x(rd_x), .rd_data(rd_data1)
    );

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a registered sprite ROM model.
// Expected flip behaviour follows SPRITE_FLIP_EN.
module tb_sprite_line_engine;

    localparam int LINE_W = 640;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect, write;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic        frame_start, line_start;
    logic [9:0]  next_line;
    logic        rd_en;
    logic [9:0]  rd_x;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy, overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_d [LINE_W];
    bit         got_v [LINE_W];

    sprite_line_engine dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .frame_start(frame_start),
        .line_start(line_start), .next_line(next_line), .rd_en(rd_en), .rd_x(rd_x),
        .pix_data(pix_data), .pix_valid(pix_valid), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .overrun(overrun)
    );

    // ---------------- clock / ROM model ----------------
    always #5 clk = ~clk;

    // Sprites 0-4: col+1; 5 and up: 0x80|(col+1); sprite 6 is transparent at col 5.
    function automatic logic [7:0] rom_val(input logic [13:0] a);
        logic [5:0] s;
        logic [7:0] c;
        s = a[13:8];
        c = {4'b0000, a[3:0]};
        if (s == 6'd6 && c == 8'd5) return 8'd0;
        if (s >= 6'd5) return 8'h80 | (c + 8'd1);
        return c + 8'd1;
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int s, input bit a, input bit f);
        return {x[11:0], y[11:0], s[5:0], a, f};
    endfunction

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < LINE_W; i++) n += int'(got_v[i]);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic build(input logic [9:0] line, input bit with_frame);
        @(negedge clk);
        line_start = 1'b1; next_line = line; frame_start = with_frame;
        @(negedge clk);
        line_start = 1'b0; frame_start = 1'b0;
        wait_idle("build_idle");
    endtask

    task automatic read_px(input logic [9:0] x);
        @(negedge clk);
        rd_en = 1'b1; rd_x = x;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic read_line();
        for (int i = 0; i <= LINE_W; i++) begin
            @(negedge clk);
            if (i > 0) begin
                got_d[i-1] = pix_data;
                got_v[i-1] = pix_valid;
            end
            rd_en = (i < LINE_W);
            rd_x  = 10'(i);
        end
        rd_en = 1'b0;
    endtask

    // Build a line, swap it to the display side with an empty build, read it all.
    task automatic show(input logic [9:0] line, input bit with_frame);
        build(line, with_frame);
        build(10'd1023, 1'b0);
        read_line();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
        frame_start = 1'b0; line_start = 1'b0; next_line = '0; rd_en = 1'b0; rd_x = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_overrun", overrun, 0);
        check("rst_pix", {pix_data, pix_valid}, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;

        // CLEAR sweep lasts exactly LINE_W cycles
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("clear_cycles", cyc, LINE_W);
        read_line();
        check("clear_all_invalid", count_valid(), 0);

        // single object: x=100 y=50 sprite 3, line 52
        reg_write(5'd1, mk(100, 50, 3, 1'b1, 1'b0));
        pulse_frame();
        build(10'd52, 1'b0);
        check("row_rom_addr", rom_addr, {6'd3, 4'd2, 4'd15});
        build(10'd1023, 1'b0);
        read_px(10'd105);
        check("single_rd", {pix_data, pix_valid}, {8'd6, 1'b1});
        repeat (3) @(negedge clk);
        check("hold_rd", {pix_data, pix_valid}, {8'd6, 1'b1});
        read_px(10'd700);
        check("oob_rd", {pix_data, pix_valid}, 0);
        read_line();
        check("obj_x99", got_v[99], 0);
        check("obj_x100", {got_d[100], got_v[100]}, {8'd1, 1'b1});
        check("obj_x115", {got_d[115], got_v[115]}, {8'd16, 1'b1});
        check("obj_x116", got_v[116], 0);
        check("clear_on_read", got_v[105], 0);
        check("obj_count", count_valid(), 15);

        // painter's order and transparency
        reg_write(5'd2, mk(200, 10, 4, 1'b1, 1'b0));
        reg_write(5'd3, mk(200, 10, 5, 1'b1, 1'b0));
        pulse_frame();
        show(10'd10, 1'b0);
        check("ovl_x200", got_d[200], 8'h81);
        check("ovl_x205", got_d[205], 8'h86);
        check("ovl_x215", got_d[215], 8'h90);
        check("ovl_x216", got_v[216], 0);
        reg_write(5'd3, mk(200, 10, 6, 1'b1, 1'b0));
        pulse_frame();
        show(10'd12, 1'b0);
        check("hole_x204", got_d[204], 8'h85);
        check("hole_x205", {got_d[205], got_v[205]}, {8'd6, 1'b1});
        check("hole_x206", got_d[206], 8'h87);

        // right edge clip and y near the top of the range
        reg_write(5'd2, 32'd0);
        reg_write(5'd3, 32'd0);
        reg_write(5'd4, mk(630, 0, 1, 1'b1, 1'b0));
        reg_write(5'd5, mk(0, 4090, 2, 1'b1, 1'b0));
        pulse_frame();
        show(10'd0, 1'b0);
        check("edge_x630", {got_d[630], got_v[630]}, {8'd1, 1'b1});
        check("edge_x639", got_d[639], 8'd10);
        check("edge_nowrap_x0", got_v[0], 0);
        check("edge_count", count_valid(), 10);

        // overrun: every object hits line 20, interrupt after 50 cycles
        for (int i = 0; i < 20; i++) reg_write(5'(i + 1), mk(i * 20, 20, 1, 1'b1, 1'b0));
        pulse_frame();
        @(negedge clk);
        line_start = 1'b1; next_line = 10'd20;
        @(negedge clk);
        line_start = 1'b0;
        repeat (50) @(negedge clk);
        check("ovr_busy", busy, 1);
        check("ovr_before", overrun, 0);
        @(negedge clk);
        line_start = 1'b1; next_line = 10'd1023;
        @(negedge clk);
        line_start = 1'b0;
        check("ovr_set", overrun, 1);
        wait_idle("ovr_idle");
        read_line();
        check("ovr_partial_x0", {got_d[0], got_v[0]}, {8'd1, 1'b1});
        check("ovr_partial_x35", got_d[35], 8'd16);
        check("ovr_unbuilt_x100", got_v[100], 0);
        reg_write(5'd0, 32'd0);
        check("ovr_keep", overrun, 1);
        reg_write(5'd0, 32'd1);
        check("ovr_clear", overrun, 0);

        // shadow registers only take effect at frame_start
        for (int i = 0; i < 20; i++) reg_write(5'(i + 1), 32'd0);
        reg_write(5'd1, mk(100, 50, 3, 1'b1, 1'b0));
        pulse_frame();
        reg_write(5'd1, mk(300, 50, 3, 1'b1, 1'b0));
        show(10'd50, 1'b0);
        check("shadow_old_x100", got_v[100], 1);
        check("shadow_new_x300", got_v[300], 0);
        pulse_frame();
        show(10'd50, 1'b0);
        check("commit_x300", {got_d[300], got_v[300]}, {8'd1, 1'b1});
        check("commit_x100", got_v[100], 0);

        reg_write(5'd1, mk(300, 50, 3, 1'b1, 1'b1));
        pulse_frame();
        show(10'd50, 1'b0);
`ifdef SPRITE_FLIP_EN
        check("flip_x300", got_d[300], 8'd16);
        check("flip_x315", got_d[315], 8'd1);
`else
        check("noflip_x300", got_d[300], 8'd1);
        check("noflip_x315", got_d[315], 8'd16);
`endif

        // commit and line start in the same cycle: scan sees the new table
        reg_write(5'd1, mk(400, 50, 3, 1'b1, 1'b0));
        show(10'd50, 1'b1);
        check("same_cycle_x400", {got_d[400], got_v[400]}, {8'd1, 1'b1});
        check("same_cycle_x300", got_v[300], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
